meas_seq_ctrl: RTL and testbench
================================

# meas_seq_ctrl

Measurement sequencer for the peak-counting datapath. It generates the sample tick that clocks the datapath and drives the measurement window enable that gates it. After each window it waits for the datapath to publish its results, then latches peak count and accumulated interval sum. A sequential divider computes the mean interval, and the result is handed to the display/UART side over a valid/ready handshake. Single-shot or continuous operation is selectable.

## Interface
- CLK_DIV, 2_500_000: system clocks per sample tick (20 Hz at 50 MHz); legal range ≥ 2
- WIN_SAMPLES, 200: sample ticks per measurement window (10 s at 20 Hz); legal range 1..65535
- SETTLE_TICKS, 3: sample ticks to wait after window close before latching datapath outputs; legal range ≥ 2
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; sampled only in IDLE; launches a measurement
- cont  in  1  1 = re-arm automatically after each result is accepted
- abort  in  1  return to IDLE from any state; has priority over all else
- sum_in  in  8  datapath accumulated interval sum
- cnt_in  in  8  datapath peak count
- sample_tick  out  1  one-clk pulse every CLK_DIV clocks; drives the datapath sample clock enable
- win_en  out  1  measurement window enable to the datapath
- busy  out  1  state ≠ IDLE
- res_valid  out  1  result available; held until accepted
- res_ready  in  1  consumer accepts the result when res_valid & res_ready
- res_sum  out  8  latched sum
- res_cnt  out  8  latched peak count
- res_avg  out  8  floor(res_sum / res_cnt); 8'hFF when res_cnt = 0
- res_err  out  1  1 when res_cnt = 0

## Operation
- Tick generator
  - Free-running counter 0..CLK_DIV-1 from reset; sample_tick = 1 in the cycle the counter equals CLK_DIV-1; wraps to 0.
  - Unaffected by the FSM and abort.
- IDLE
  - win_en = 0.
  - start = 1 → ARM.
- ARM
  - Wait for sample_tick.
  - On tick → MEASURE: win_en = 1 from the next cycle; window tick counter cleared.
- MEASURE
  - win_en = 1; count sample ticks.
  - On the WIN_SAMPLES-th tick: win_en = 0 next cycle → SETTLE; settle counter cleared.
- SETTLE
  - win_en = 0; count sample ticks.
  - On the SETTLE_TICKS-th tick: latch sum_in → res_sum and cnt_in → res_cnt → DIV.
- DIV
  - 8-iteration restoring division, one iteration per clk.
  - If res_cnt = 0: skip iterations, res_avg = 8'hFF, res_err = 1, go directly → OUT next cycle.
  - Otherwise res_err = 0; after the 8th iteration → OUT.
- OUT
  - res_valid = 1; res_sum, res_cnt, res_avg and res_err held stable.
  - On res_valid & res_ready: res_valid = 0 next cycle → ARM if cont = 1, else IDLE.
- Abort
  - abort = 1 in any state → IDLE next cycle; win_en = 0, res_valid = 0.
  - Result registers keep their last values.
  - abort and start high together in IDLE → stay in IDLE.
- Width rules
  - Window counter is 16 bits; settle counter is 8 bits.
  - Quotient is 8 bits; 8-bit divisor, 9-bit partial remainder.
- win_en low for ≥ 2 ticks in SETTLE lets the datapath publish its results and clear its accumulators.

## Timing
- Reset values: sample_tick 0, win_en 0, busy 0, res_valid 0, res_sum 0, res_cnt 0, res_avg 0, res_err 0; FSM in IDLE; all counters 0.
- First sample_tick occurs CLK_DIV clocks after rst deasserts.
- start → busy = 1 one cycle later.
- Window length: win_en high for exactly WIN_SAMPLES·CLK_DIV clocks.
- Window close to result: SETTLE_TICKS·CLK_DIV clocks + 1 latch cycle + 8 DIV cycles (1 if cnt = 0) + 1 cycle to res_valid.
- res_ready may be held high in advance; the handshake completes in the first cycle res_valid = 1.
- Reset mid-window: win_en drops asynchronously.

## Test plan
- CLK_DIV=4, WIN_SAMPLES=5, SETTLE_TICKS=2:
  - Pulse start → win_en high exactly 20 clks, starting the cycle after a tick.
  - res_valid rises 2·4+10 clks after win_en falls.
- sum_in=100, cnt_in=7 → res_avg=14, res_err=0.
- sum_in=255, cnt_in=1 → res_avg=255, res_err=0.
- sum_in=50, cnt_in=0 → res_avg=8'hFF, res_err=1.
- res_ready held low 30 clks:
  - res_valid and outputs stable throughout.
  - Raise ready → res_valid drops next cycle.
  - With cont=1, win_en rises again after the next tick; with cont=0, busy=0.
- abort asserted mid-MEASURE → win_en=0 and busy=0 next cycle; res_* unchanged.
- rst asserted during DIV → all outputs at reset values immediately; a subsequent start runs a clean window.

Source files
------------

// File: rtl/meas_seq_ctrl.sv
// Measurement sequencer: free-running sample tick, windowed enable, settle, latch, 8-step restoring divide.
// Result is held on res_valid until res_ready; abort returns to IDLE from any state, result registers persist.
module meas_seq_ctrl #(
  parameter int CLK_DIV      = 2_500_000,
  parameter int WIN_SAMPLES  = 200,
  parameter int SETTLE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       abort,
  input  logic [7:0] sum_in,
  input  logic [7:0] cnt_in,
  output logic       sample_tick,
  output logic       win_en,
  output logic       busy,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_sum,
  output logic [7:0] res_cnt,
  output logic [7:0] res_avg,
  output logic       res_err
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST   = TW'(CLK_DIV - 1);
  localparam logic [15:0]   WIN_LAST    = 16'(WIN_SAMPLES - 1);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_TICKS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_DIV     = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  // Divide step sequencing: 0 = load, 1..8 = iterations, 9 = publish result.
  localparam logic [3:0] DIV_LOAD = 4'd0;
  localparam logic [3:0] DIV_LAST = 4'd8;
  localparam logic [3:0] DIV_PUB  = 4'd9;

  logic [TW-1:0] tick_cnt;
  logic [2:0]    state;
  logic [15:0]   win_cnt;
  logic [7:0]    set_cnt;
  logic [3:0]    div_step;
  logic [8:0]    rem;
  logic [7:0]    quo;
  logic          zero_div;

  logic [8:0]    rem_shift;
  logic [8:0]    rem_next;
  logic          q_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign sample_tick = (tick_cnt == TICK_LAST);

  // Remainder never exceeds the divisor, so its top bit is always clear before the shift.
  assign rem_shift = 9'({rem, quo[7]});
  assign q_bit     = (rem_shift >= {1'b0, res_cnt});
  assign rem_next  = q_bit ? (rem_shift - {1'b0, res_cnt}) : rem_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      win_cnt  <= '0;
      set_cnt  <= '0;
      div_step <= '0;
      rem      <= '0;
      quo      <= '0;
      zero_div <= 1'b0;
      res_sum  <= '0;
      res_cnt  <= '0;
      res_avg  <= '0;
      res_err  <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_ARM;
        end
        S_ARM: begin
          if (sample_tick) begin
            state   <= S_MEASURE;
            win_cnt <= '0;
          end
        end
        S_MEASURE: begin
          if (sample_tick) begin
            if (win_cnt == WIN_LAST) begin
              state   <= S_SETTLE;
              set_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 16'd1;
            end
          end
        end
        S_SETTLE: begin
          if (sample_tick) begin
            if (set_cnt == SETTLE_LAST) begin
              res_sum  <= sum_in;
              res_cnt  <= cnt_in;
              div_step <= DIV_LOAD;
              state    <= S_DIV;
            end else begin
              set_cnt <= set_cnt + 8'd1;
            end
          end
        end
        S_DIV: begin
          if (div_step == DIV_LOAD) begin
            rem      <= '0;
            quo      <= res_sum;
            zero_div <= (res_cnt == 8'd0);
            // A zero divisor spends a single idle step before publishing.
            div_step <= (res_cnt == 8'd0) ? DIV_LAST : 4'd1;
          end else if (div_step == DIV_PUB) begin
            res_avg <= zero_div ? 8'hFF : quo;
            res_err <= zero_div;
            state   <= S_OUT;
          end else begin
            if (!zero_div) begin
              rem <= rem_next;
              quo <= {quo[6:0], q_bit};
            end
            div_step <= div_step + 4'd1;
          end
        end
        S_OUT: begin
          if (res_ready) state <= cont ? S_ARM : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign win_en    = (state == S_MEASURE);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_OUT);

endmodule

// File: tb/tb_meas_seq_ctrl.sv
module tb_meas_seq_ctrl;

  localparam int C = 4;
  localparam int W = 5;
  localparam int S = 2;
  localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] sum_in = 8'd0;
  logic [7:0] cnt_in = 8'd0;
  logic       sample_tick, win_en, busy, res_valid, res_err;
  logic [7:0] res_sum, res_cnt, res_avg;

  int n_checks = 0;
  int n_errors = 0;

  meas_seq_ctrl #(.CLK_DIV(C), .WIN_SAMPLES(W), .SETTLE_TICKS(S)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .sum_in(sum_in), .cnt_in(cnt_in),
    .sample_tick(sample_tick), .win_en(win_en), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cnt(res_cnt), .res_avg(res_avg), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: cycles counted from reset release, events placed by arithmetic on that count.
  longint     cyc;
  bit         m_active;
  longint     m_wstart, m_wend, m_latch, m_valid;
  logic [7:0] m_sum, m_cnt, m_avg, p_avg;
  logic       m_err, p_err;

  task automatic schedule(input longint k);
    longint t;
    t = k + 1;
    while ((t % C) != C - 1) t++;
    m_active = 1'b1;
    m_wstart = t + 1;
    m_wend   = m_wstart + W * C;
    m_latch  = m_wend + S * C - 1;
    m_valid  = NEVER;
  endtask

  initial begin
    bit exp_win, exp_valid;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_tick", 32'(sample_tick), 0);
        chk("rst_win", 32'(win_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_sum", 32'(res_sum), 0);
        chk("rst_cnt", 32'(res_cnt), 0);
        chk("rst_avg", 32'(res_avg), 0);
        chk("rst_err", 32'(res_err), 0);
        cyc = 0; m_active = 1'b0;
        m_wstart = NEVER; m_wend = NEVER; m_latch = NEVER; m_valid = NEVER;
        m_sum = 0; m_cnt = 0; m_avg = 0; m_err = 0; p_avg = 0; p_err = 0;
      end else begin
        exp_win   = m_active && cyc >= m_wstart && cyc < m_wend;
        exp_valid = m_active && cyc >= m_valid;
        chk("m_tick", 32'(sample_tick), 32'((cyc % C) == C - 1));
        chk("m_win", 32'(win_en), 32'(exp_win));
        chk("m_busy", 32'(busy), 32'(m_active));
        chk("m_valid", 32'(res_valid), 32'(exp_valid));
        chk("m_sum", 32'(res_sum), 32'(m_sum));
        chk("m_cnt", 32'(res_cnt), 32'(m_cnt));
        chk("m_avg", 32'(res_avg), 32'(m_avg));
        chk("m_err", 32'(res_err), 32'(m_err));
        if (m_active) begin
          if (abort) begin
            m_active = 1'b0;
          end else begin
            if (cyc == m_latch) begin
              m_sum   = sum_in;
              m_cnt   = cnt_in;
              p_err   = (cnt_in == 0);
              p_avg   = (cnt_in == 0) ? 8'hFF : sum_in / cnt_in;
              m_valid = cyc + 1 + ((cnt_in == 0) ? 3 : 10);
            end
            if (cyc + 1 == m_valid) begin
              m_avg = p_avg;
              m_err = p_err;
            end
            if (exp_valid && res_ready) begin
              if (cont) schedule(cyc);
              else m_active = 1'b0;
            end
          end
        end else if (start && !abort) begin
          schedule(cyc);
        end
        cyc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic directed_run(input logic [7:0] s, input logic [7:0] c,
                              input logic [7:0] exp_avg, input logic exp_err, input int exp_gap);
    int   n;
    logic prev_tick;
    sum_in = s; cnt_in = c; res_ready = 1'b1; cont = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    n = 0; prev_tick = 1'b0;
    while (!win_en && n < 50) begin prev_tick = sample_tick; step(); n++; end
    chk("win_rise_in_time", 32'(n < 50), 1);
    chk("tick_before_win", 32'(prev_tick), 1);
    n = 0;
    while (win_en && n < 100) begin step(); n++; end
    chk("win_len", 32'(n), 20);
    n = 0;
    while (!res_valid && n < 100) begin step(); n++; end
    chk("close_to_valid", 32'(n), 32'(exp_gap));
    chk("d_sum", 32'(res_sum), 32'(s));
    chk("d_cnt", 32'(res_cnt), 32'(c));
    chk("d_avg", 32'(res_avg), 32'(exp_avg));
    chk("d_err", 32'(res_err), 32'(exp_err));
    step();
    chk("valid_drop", 32'(res_valid), 0);
    chk("idle_after_accept", 32'(busy), 0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) step();

    directed_run(8'd100, 8'd7, 8'd14, 1'b0, 18);
    directed_run(8'd255, 8'd1, 8'd255, 1'b0, 18);
    directed_run(8'd50, 8'd0, 8'hFF, 1'b1, 11);

    // Consumer stalls, then accepts with continuous mode; the re-armed window is aborted.
    sum_in = 8'd200; cnt_in = 8'd9; res_ready = 1'b0; cont = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!res_valid && n < 200) begin step(); n++; end
    chk("stall_valid_in_time", 32'(n < 200), 1);
    sum_in = 8'd1; cnt_in = 8'd3;
    for (int i = 0; i < 30; i++) begin
      chk("stall_valid", 32'(res_valid), 1);
      chk("stall_sum", 32'(res_sum), 200);
      chk("stall_cnt", 32'(res_cnt), 9);
      chk("stall_avg", 32'(res_avg), 22);
      chk("stall_err", 32'(res_err), 0);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("accept_drop", 32'(res_valid), 0);
    chk("cont_busy", 32'(busy), 1);
    n = 0;
    while (!win_en && n < 50) begin step(); n++; end
    chk("cont_rearm", 32'(win_en), 1);
    repeat (6) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_win", 32'(win_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sum", 32'(res_sum), 200);
    chk("abort_avg", 32'(res_avg), 22);
    cont = 1'b0;
    repeat (3) step();

    // Reset while dividing, then a clean run.
    sum_in = 8'd100; cnt_in = 8'd7; res_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!win_en && n < 50) begin step(); n++; end
    n = 0;
    while (win_en && n < 100) begin step(); n++; end
    repeat (S * C + 3) step();
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tick", 32'(sample_tick), 0);
    chk("arst_sum", 32'(res_sum), 0);
    chk("arst_cnt", 32'(res_cnt), 0);
    chk("arst_avg", 32'(res_avg), 0);
    chk("arst_valid", 32'(res_valid), 0);
    step(); step();
    rst = 1'b0;
    directed_run(8'd100, 8'd7, 8'd14, 1'b0, 18);

    for (int i = 0; i < 3000; i++) begin
      sum_in    = 8'($urandom);
      cnt_in    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      res_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 9) == 0);
      abort     = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) cont = ~cont;
      step();
    end
    start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
